// File: rtl/prog_freqdiv.sv
// Runtime-programmable integer clock divider with exact 50% duty for even and odd N,
// glitch-free divisor reload at period boundaries, period-start tick and phase restart.
module prog_freqdiv #(
  parameter int WIDTH   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sync,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_val,
  output logic [WIDTH-1:0] cur_div,
  output logic             div_pend,
  output logic             div_err,
  output logic             tick,
  output logic             clk_out
);

  localparam logic [WIDTH-1:0] DEF_N = WIDTH'(DEF_DIV);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] pend_div;
  logic [WIDTH-1:0] nxt_div;
  logic [WIDTH-1:0] nxt_pend_div;
  logic             nxt_pend;
  logic             load_ok;
  logic             load_bad;
  logic             at_wrap;
  logic             hi_p;
  logic             hi_n;
  logic             run_q;
  logic             hi_next;
  logic             tick_next;

  assign load_ok  = div_load && (div_val >= TWO);
  assign load_bad = div_load && (div_val < TWO);
  assign at_wrap  = (cnt == (cur_div - ONE));

  always_comb begin
    nxt_div      = cur_div;
    nxt_pend_div = pend_div;
    nxt_pend     = div_pend;
    cnt_next     = cnt + ONE;
    if (!sync) begin
      // Restart: park the counter so the first edge after release is a boundary.
      if (load_ok) begin
        nxt_div = div_val;
      end else if (div_pend) begin
        nxt_div = pend_div;
      end
      nxt_pend_div = nxt_div;
      nxt_pend     = 1'b0;
      cnt_next     = nxt_div - ONE;
    end else begin
      if (at_wrap) begin
        cnt_next = '0;
        if (div_pend) begin
          nxt_div  = pend_div;
          nxt_pend = 1'b0;
        end
      end
      // A load on a boundary edge stays pending for the following boundary.
      if (load_ok) begin
        nxt_pend_div = div_val;
        nxt_pend     = 1'b1;
      end
    end
    hi_next   = sync && (cnt_next < (nxt_div >> 1));
    tick_next = sync && (cnt_next == '0);
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt      <= DEF_N - ONE;
      cur_div  <= DEF_N;
      pend_div <= DEF_N;
      div_pend <= 1'b0;
      div_err  <= 1'b0;
      tick     <= 1'b0;
      hi_p     <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      cur_div  <= nxt_div;
      pend_div <= nxt_pend_div;
      div_pend <= nxt_pend;
      div_err  <= load_bad;
      tick     <= tick_next;
      hi_p     <= hi_next;
      run_q    <= sync;
    end
  end

  always_ff @(negedge clk_in or negedge rst) begin
    if (!rst) begin
      hi_n <= 1'b0;
    end else begin
      hi_n <= hi_p & cur_div[0];
    end
  end

  // run_q drops with hi_p so a restart cannot leave the half-cycle extension high.
  assign clk_out = hi_p | (hi_n & run_q);

endmodule

// File: tb/tb_prog_freqdiv.sv
// Self-checking bench for prog_freqdiv: directed vector table, hand sequences for
// odd duty / phase restart / reset, and randomized traffic against a half-cycle model.
module tb_prog_freqdiv;

  logic       clk_in;
  logic       rst;
  logic       sync;
  logic       div_load;
  logic [7:0] div_val;
  logic [7:0] cur_div;
  logic       div_pend;
  logic       div_err;
  logic       tick;
  logic       clk_out;

  int tests = 0;
  int fails = 0;

  prog_freqdiv #(.WIDTH(8), .DEF_DIV(2)) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .sync    (sync),
    .div_load(div_load),
    .div_val (div_val),
    .cur_div (cur_div),
    .div_pend(div_pend),
    .div_err (div_err),
    .tick    (tick),
    .clk_out (clk_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Behavioural model: position within the output period and the divisor in force.
  int m_n, m_pos, m_pendv;
  bit m_pend, m_run, m_tick, m_err;

  // Sampled DUT outputs of the last cycle (c1: first half, c2: second half).
  int a_tick, a_c1, a_c2, a_cur, a_pend, a_err;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 2; m_pos = 1; m_pend = 0; m_pendv = 2; m_run = 0; m_tick = 0; m_err = 0;
  endtask

  task automatic model_step(input bit s, input bit l, input int v);
    bit lv;
    m_err = l && (v < 2);
    lv    = l && (v >= 2);
    if (!s) begin
      if (lv) m_n = v;
      else if (m_pend) m_n = m_pendv;
      m_pend = 0;
      m_pos  = m_n - 1;
      m_run  = 0;
      m_tick = 0;
    end else begin
      m_pos++;
      if (m_pos >= m_n) begin
        m_pos = 0;
        if (m_pend) begin
          m_n = m_pendv;
          m_pend = 0;
        end
      end
      if (lv) begin
        m_pend = 1;
        m_pendv = v;
      end
      m_run  = 1;
      m_tick = (m_pos == 0);
    end
  endtask

  // One clk_in cycle; entered and left just after a falling edge.
  task automatic cycle(input bit s, input bit l, input int v, input bit chk);
    sync = s; div_load = l; div_val = 8'(v);
    @(posedge clk_in);
    model_step(s, l, v);
    #1;
    a_tick = int'(tick); a_c1 = int'(clk_out); a_cur = int'(cur_div);
    a_pend = int'(div_pend); a_err = int'(div_err);
    @(negedge clk_in);
    #1;
    a_c2 = int'(clk_out);
    div_load = 1'b0;
    if (chk) begin
      // clk_out is high while the half-cycle index 2*pos(+1) is below N.
      check("rnd_tick", a_tick, int'(m_tick));
      check("rnd_clk_rise_half", a_c1, int'(m_run && (2 * m_pos < m_n)));
      check("rnd_clk_fall_half", a_c2, int'(m_run && (2 * m_pos + 1 < m_n)));
      check("rnd_cur_div", a_cur, m_n);
      check("rnd_div_pend", a_pend, int'(m_pend));
      check("rnd_div_err", a_err, int'(m_err));
    end
  endtask

  typedef struct {
    int s; int l; int v;
    int e_tick; int e_c1; int e_c2; int e_cur; int e_pend; int e_err;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int pat;
    int found;
    rst = 1'b0; sync = 1'b1; div_load = 1'b0; div_val = '0;
    model_reset();

    tbl[0]  = '{1, 0, 0, 1, 1, 1, 2, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 0, 2, 0, 0};
    tbl[2]  = '{1, 1, 4, 1, 1, 1, 2, 1, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 0, 2, 1, 0};
    tbl[4]  = '{1, 0, 0, 1, 1, 1, 4, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 1, 1, 4, 0, 0};
    tbl[6]  = '{1, 0, 0, 0, 0, 0, 4, 0, 0};
    tbl[7]  = '{1, 0, 0, 0, 0, 0, 4, 0, 0};
    tbl[8]  = '{1, 0, 0, 1, 1, 1, 4, 0, 0};
    tbl[9]  = '{1, 1, 6, 0, 1, 1, 4, 1, 0};
    tbl[10] = '{1, 1, 3, 0, 0, 0, 4, 1, 0};
    tbl[11] = '{1, 0, 0, 0, 0, 0, 4, 1, 0};
    tbl[12] = '{1, 0, 0, 1, 1, 1, 3, 0, 0};
    tbl[13] = '{1, 0, 0, 0, 1, 0, 3, 0, 0};
    tbl[14] = '{1, 0, 0, 0, 0, 0, 3, 0, 0};
    tbl[15] = '{1, 1, 1, 1, 1, 1, 3, 0, 1};
    tbl[16] = '{1, 1, 0, 0, 1, 0, 3, 0, 1};
    tbl[17] = '{1, 0, 0, 0, 0, 0, 3, 0, 0};
    tbl[18] = '{1, 0, 0, 1, 1, 1, 3, 0, 0};

    #12;
    check("reset_clk_out", int'(clk_out), 0);
    check("reset_tick", int'(tick), 0);
    check("reset_cur_div", int'(cur_div), 2);
    check("reset_div_pend", int'(div_pend), 0);
    check("reset_div_err", int'(div_err), 0);
    @(negedge clk_in);
    #1 rst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].s[0], tbl[i].l[0], tbl[i].v, 1'b0);
      check($sformatf("vec%0d_tick", i), a_tick, tbl[i].e_tick);
      check($sformatf("vec%0d_clk_rise_half", i), a_c1, tbl[i].e_c1);
      check($sformatf("vec%0d_clk_fall_half", i), a_c2, tbl[i].e_c2);
      check($sformatf("vec%0d_cur_div", i), a_cur, tbl[i].e_cur);
      check($sformatf("vec%0d_div_pend", i), a_pend, tbl[i].e_pend);
      check($sformatf("vec%0d_div_err", i), a_err, tbl[i].e_err);
    end

    // Odd N=5: 2.5 cycles high, 2.5 low, period 5.
    cycle(1'b1, 1'b1, 5, 1'b1);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      cycle(1'b1, 1'b0, 0, 1'b1);
      if (a_tick == 1 && a_cur == 5) found = 1;
    end
    check("n5_boundary_reached", found, 1);
    pat = (a_c1 << 9) | (a_c2 << 8);
    for (int k = 1; k < 5; k++) begin
      cycle(1'b1, 1'b0, 0, 1'b1);
      check($sformatf("n5_no_tick_%0d", k), a_tick, 0);
      pat |= (a_c1 << (9 - 2 * k)) | (a_c2 << (8 - 2 * k));
    end
    check("n5_half_cycle_pattern", pat, 10'b1111100000);
    cycle(1'b1, 1'b0, 0, 1'b1);
    check("n5_period_tick", a_tick, 1);

    for (int k = 0; k < 400; k++) begin
      bit s, l;
      int v;
      s = ($urandom_range(0, 15) != 0);
      l = ($urandom_range(0, 7) == 0);
      v = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 12));
      cycle(s, l, v, 1'b1);
    end

    // Phase restart mid-high-phase of N=7 with a load of 8 during the hold.
    cycle(1'b1, 1'b1, 7, 1'b1);
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      cycle(1'b1, 1'b0, 0, 1'b1);
      if (a_tick == 1 && a_cur == 7) found = 1;
    end
    check("n7_boundary_reached", found, 1);
    cycle(1'b1, 1'b0, 0, 1'b1);
    check("n7_mid_high", a_c1, 1);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, k == 1, 8, 1'b1);
      check($sformatf("sync_hold%0d_clk_rise_half", k), a_c1, 0);
      check($sformatf("sync_hold%0d_clk_fall_half", k), a_c2, 0);
      check($sformatf("sync_hold%0d_tick", k), a_tick, 0);
      check($sformatf("sync_hold%0d_cur_div", k), a_cur, (k == 0) ? 7 : 8);
    end
    cycle(1'b1, 1'b0, 0, 1'b1);
    check("sync_release_tick", a_tick, 1);
    check("sync_release_clk", a_c1, 1);
    check("sync_release_cur_div", a_cur, 8);

    // Reset asserted while clk_out is high truncates it at once.
    check("pre_reset_clk_high", int'(clk_out), 1);
    rst = 1'b0;
    #1;
    check("midperiod_reset_clk_out", int'(clk_out), 0);
    check("midperiod_reset_cur_div", int'(cur_div), 2);
    check("midperiod_reset_tick", int'(tick), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prog_freqdiv.md
# prog_freqdiv

Runtime-programmable integer clock divider. It generates `clk_out` at f(`clk_in`)/N with exact 50% duty for both even and odd N. N can be reloaded on the fly, and the change is applied glitch-free at the next output period boundary. It also provides a period-start strobe, `tick`, for logic clocked by `clk_in`, and a synchronous phase-restart input so several dividers can be phase-aligned.

## Interface
- `WIDTH`, 8: width of the divisor and the counter. Legal N range is 2..2^WIDTH-1.
- `DEF_DIV`, 2: divisor loaded at reset. Must lie in 2..2^WIDTH-1.

Ports:
- `clk_in`, in, 1: source clock. Logic uses the rising edge; the odd-duty path also uses the falling edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `sync`, in, 1: synchronous phase restart, active-low.
- `div_load`, in, 1: one-cycle strobe; samples `div_val`.
- `div_val`, in, WIDTH: requested divisor N.
- `cur_div`, out, WIDTH: divisor currently in effect.
- `div_pend`, out, 1: a valid divisor is waiting for the next boundary.
- `div_err`, out, 1: one-cycle pulse when a load is rejected.
- `tick`, out, 1: one `clk_in`-cycle pulse in the first cycle of each output period.
- `clk_out`, out, 1: divided clock.

## Operation
State:
- Counter `cnt`, WIDTH bits.
- Divisor registers `cur_div` and `pend_div`, plus the flag `div_pend`.
- Posedge phase register `hi_p`.
- Negedge phase register `hi_n`.

Counting:
- `cnt` counts 0..N-1 and wraps to 0. The edge on which it wraps is the **boundary**.
- Registered on the rising edge: `hi_p <= (cnt_next < (N>>1))` and `tick <= (cnt_next == 0)`.

Duty cycle:
- Even N: `clk_out = hi_p`. High for N/2 cycles, low for N/2 cycles.
- Odd N: `hi_n` samples `hi_p` on the falling edge of `clk_in`, and `clk_out = hi_p | hi_n`.
  - High for (N-1)/2 + 0.5 cycles, low for the rest.
  - `hi_n` is forced to 0 whenever `cur_div` is even.

Divisor loading:
- `div_load`=1 with `div_val` >= 2:
  - `pend_div <= div_val` and `div_pend <= 1`.
  - A later load before the boundary overwrites the pending value; the last load wins.
- `div_load`=1 with `div_val` < 2:
  - Pulse `div_err` for one cycle.
  - `cur_div`, `pend_div` and `div_pend` are unchanged.
- At a boundary with `div_pend`=1:
  - `cur_div <= pend_div` and `div_pend <= 0`.
  - The new N governs the `hi_p` compare from `cnt_next`=0 onward, so the first high phase under the new N has its full length.
- A load sampled on the same edge as a boundary is held pending and applies at the following boundary.

Phase restart (`sync`=0):
- `cnt <= cur_div-1`; `hi_p`, `hi_n` and `tick` are held at 0.
- Any pending divisor is applied immediately.
- Loads are still accepted and are applied immediately while `sync`=0.
- The first rising edge with `sync`=1 is a boundary.

Reset (`rst`=0):
- `cur_div`=`DEF_DIV`, `pend_div`=`DEF_DIV`, `cnt`=`DEF_DIV`-1.
- `div_pend`=0, `div_err`=0, `tick`=0, `hi_p`=0, `hi_n`=0, so `clk_out`=0.
- Reset asserted mid-period truncates the output low immediately. No other glitch source exists.

## Timing
- First rising edge of `clk_in` after `rst` is released (with `sync`=1): `clk_out` rises and `tick`=1.
- `clk_out` rising edges coincide with `clk_in` rising edges, one register delay.
- Odd N: the falling edge of `clk_out` is half a cycle later than the falling edge of `hi_p`.
- `div_err` asserts 1 cycle after the `div_load` edge.
- `div_pend` asserts 1 cycle after the load edge.
- `cur_div` changes exactly on a boundary edge, or on a load edge while `sync`=0.
- Load-to-effect latency ranges from 1 to N_old cycles.
- Maximum N is 2^WIDTH-1. The counter never exceeds `cur_div`-1, so it cannot overflow.

## Test plan
- Reset, `DEF_DIV`=2, `sync`=1: `clk_out` toggles every cycle from the first edge; `tick` is high in every other cycle; `cur_div`=2.
- Load N=4: after the boundary, `clk_out` is high for 2 cycles and low for 2; `tick` has period 4; `div_pend` clears on the boundary.
- Load N=5: `clk_out` is high for 2.5 cycles and low for 2.5 (check both clock edges); period is 5 cycles.
- Load N=6 at `cnt`=1 of an N=4 period, then N=3 before the boundary: no short pulse occurs; the next period uses N=3; N=6 is never applied.
- Load `div_val`=1 and `div_val`=0: `div_err` pulses once for each; `cur_div` is unchanged; the waveform is undisturbed.
- With N=7 running, hold `sync`=0 for 3 cycles mid-high-phase, with a load of N=8 during that time: `clk_out` is 0 and `tick` is 0 during the hold; `cur_div`=8 immediately; on the first edge after release, `clk_out` rises with `tick`=1.
